// File: rtl/seq_shift_unit_if.sv
// ----------------------------------------------------------------------------
// seq_shift_unit_if
//
// Request/response bundle for the multi-cycle shift/rotate unit.
//
// Request side (driven by the issuing stage, master modport):
//   start      - request strobe, only honoured while the unit is idle or done
//   shift_in   - operand (WIDTH bits)
//   shift_val  - shift amount (SHW bits, 0..2^SHW-1)
//   mode       - 00/10 = SRL, 01 = ROL, 11 = illegal
//
// Response side (driven by the unit, slave modport):
//   busy       - operation in progress
//   done       - one-cycle completion pulse
//   err        - completed operation used the illegal mode (valid with done)
//   shift_out  - registered result
//   flag       - registered flags {N, V, Z}; only Z can ever be set
// ----------------------------------------------------------------------------
interface seq_shift_unit_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);

  logic             start;
  logic [WIDTH-1:0] shift_in;
  logic [SHW-1:0]   shift_val;
  logic [1:0]       mode;

  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] shift_out;
  logic [2:0]       flag;

  modport master (
    output start, shift_in, shift_val, mode,
    input  busy, done, err, shift_out, flag
  );

  modport slave (
    input  start, shift_in, shift_val, mode,
    output busy, done, err, shift_out, flag
  );

endinterface : seq_shift_unit_if

// File: rtl/seq_shift_unit.sv
// ----------------------------------------------------------------------------
// seq_shift_unit
//
// Multi-cycle shift/rotate unit for the directions the single-cycle barrel
// shifter does not cover: logical shift right (SRL) and rotate left (ROL).
// One bit is shifted per clock; completion is reported by a one-cycle done
// pulse together with a registered result and flags.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - asynchronous, active-low reset
//   bus    - seq_shift_unit_if.slave
//              in : start, shift_in, shift_val, mode
//              out: busy, done, err, shift_out, flag
//
// Timing seen from the accepting edge (edge 0):
//   mode 11, shift_val 0 or 1 : done in the cycle right after edge 0
//   shift_val = n >= 2        : busy for n-1 cycles, done in cycle n
// The accepting edge already performs the first shift, so the counter holds
// the number of shifts still outstanding and RUN ends when it reads 1.
// All outputs come straight from flops or from a decode of the state flops.
// ----------------------------------------------------------------------------
module seq_shift_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_shift_unit_if.slave bus
);

  // Flag bit positions, shared with the ALU flag format.
  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  // FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Operation encodings (00 and 10 both select SRL).
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_ILL = 2'b11;

  localparam logic [SHW-1:0]   CNT_ZERO  = {SHW{1'b0}};
  localparam logic [SHW-1:0]   CNT_ONE   = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  // One single-bit step of the selected operation.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] value,
    input logic [1:0]       op
  );
    logic [WIDTH-1:0] res;
    if (op == MODE_ROL) begin
      res = {value[WIDTH-2:0], value[WIDTH-1]};
    end else begin
      res = {1'b0, value[WIDTH-1:1]};
    end
    return res;
  endfunction

  // Flag vector for a result: zero detect only, V and N are never set here.
  function automatic logic [2:0] flags_of(input logic [WIDTH-1:0] value);
    logic [2:0] f;
    f         = 3'b000;
    f[FLAG_Z] = (value == DATA_ZERO);
    f[FLAG_V] = 1'b0;
    f[FLAG_N] = 1'b0;
    return f;
  endfunction

  // State and datapath flops.
  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [SHW-1:0]   cnt_q,       cnt_d;
  logic [1:0]       op_q,        op_d;
  logic [WIDTH-1:0] shift_out_q, shift_out_d;
  logic [2:0]       flag_q,      flag_d;
  logic             err_q,       err_d;

  // Shifted values: first step on the incoming operand, later steps on acc.
  logic [WIDTH-1:0] first_step_s;
  logic [WIDTH-1:0] run_step_s;

  assign first_step_s = shift_step(bus.shift_in, bus.mode);
  assign run_step_s   = shift_step(acc_q, op_q);

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    shift_out_d = shift_out_q;
    flag_d      = flag_q;
    // err is only ever high in the single DONE cycle it belongs to.
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          op_d = bus.mode;
          if (bus.mode == MODE_ILL) begin
            // Illegal op: complete immediately with a zero result.
            acc_d       = bus.shift_in;
            cnt_d       = bus.shift_val;
            state_d     = ST_DONE;
            shift_out_d = DATA_ZERO;
            flag_d      = flags_of(DATA_ZERO);
            err_d       = 1'b1;
          end else if (bus.shift_val == CNT_ZERO) begin
            // Shift by zero passes the operand through in one edge.
            acc_d       = bus.shift_in;
            cnt_d       = CNT_ZERO;
            state_d     = ST_DONE;
            shift_out_d = bus.shift_in;
            flag_d      = flags_of(bus.shift_in);
          end else begin
            // First shift happens on the accepting edge itself.
            acc_d = first_step_s;
            cnt_d = bus.shift_val - CNT_ONE;
            if (bus.shift_val == CNT_ONE) begin
              state_d     = ST_DONE;
              shift_out_d = first_step_s;
              flag_d      = flags_of(first_step_s);
            end else begin
              state_d = ST_RUN;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // start is ignored here; requests arriving now are simply lost.
        acc_d = run_step_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d     = ST_DONE;
          shift_out_d = run_step_s;
          flag_d      = flags_of(run_step_s);
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register bank with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= DATA_ZERO;
      cnt_q       <= CNT_ZERO;
      op_q        <= 2'b00;
      shift_out_q <= DATA_ZERO;
      flag_q      <= 3'b000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      shift_out_q <= shift_out_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
    end
  end

  // Status outputs are decodes of the state flops only.
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = err_q;
  assign bus.shift_out = shift_out_q;
  assign bus.flag      = flag_q;

endmodule : seq_shift_unit

// File: tb/tb_seq_shift_unit.sv
// ----------------------------------------------------------------------------
// tb_seq_shift_unit
//
// Directed bench for seq_shift_unit. A latency/arithmetic model predicts
// busy/done/err/shift_out/flag every cycle; hand-computed literals pin the
// individual scenarios.
// ----------------------------------------------------------------------------
module tb_seq_shift_unit;

  localparam int FLAG_Z = 0;

  logic clk;
  logic rst_n;

  seq_shift_unit_if #(.WIDTH(16), .SHW(4)) bus ();

  seq_shift_unit #(.WIDTH(16), .SHW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_result(input logic [15:0] x, input int n, input logic [1:0] md);
    logic [31:0] w;
    w = {16'h0000, x};
    if (md == 2'b11) return 16'h0000;
    if (md == 2'b01) begin
      w = (w << n) | (w >> (16 - n));
      return w[15:0];
    end
    w = w >> n;
    return w[15:0];
  endfunction

  function automatic int ref_latency(input int n, input logic [1:0] md);
    if (md == 2'b11) return 1;
    if (n <= 1) return 1;
    return n;
  endfunction

  function automatic logic [2:0] ref_flag(input logic [15:0] r);
    logic [2:0] f;
    f = 3'b000;
    f[FLAG_Z] = (r == 16'h0000);
    return f;
  endfunction

  logic        m_busy, m_done, m_err;
  logic [15:0] m_out, m_pend;
  logic [2:0]  m_flag;
  int          m_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_out  <= 16'h0000; m_pend <= 16'h0000; m_flag <= 3'b000; m_rem <= 0;
    end else if (m_busy) begin
      if (m_rem <= 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_err <= 1'b0;
        m_out  <= m_pend; m_flag <= ref_flag(m_pend);
      end else begin
        m_rem <= m_rem - 1;
      end
    end else if (bus.start) begin
      if (ref_latency(int'(bus.shift_val), bus.mode) == 1) begin
        m_done <= 1'b1;
        m_err  <= (bus.mode == 2'b11);
        m_out  <= ref_result(bus.shift_in, int'(bus.shift_val), bus.mode);
        m_flag <= ref_flag(ref_result(bus.shift_in, int'(bus.shift_val), bus.mode));
      end else begin
        m_busy <= 1'b1; m_done <= 1'b0; m_err <= 1'b0;
        m_rem  <= ref_latency(int'(bus.shift_val), bus.mode) - 1;
        m_pend <= ref_result(bus.shift_in, int'(bus.shift_val), bus.mode);
      end
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_busy", {31'd0, bus.busy}, {31'd0, m_busy});
    chk("cyc_done", {31'd0, bus.done}, {31'd0, m_done});
    chk("cyc_err",  {31'd0, bus.err},  {31'd0, m_err});
    chk("cyc_out",  {16'd0, bus.shift_out}, {16'd0, m_out});
    chk("cyc_flag", {29'd0, bus.flag}, {29'd0, m_flag});
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [15:0] x, input logic [3:0] n, input logic [1:0] md);
    bus.start     = 1'b1;
    bus.shift_in  = x;
    bus.shift_val = n;
    bus.mode      = md;
  endtask

  // Issue one request and wait (bounded) for done; checks literal results.
  task automatic run_op(input string nm, input logic [15:0] x, input logic [3:0] n,
                        input logic [1:0] md, input logic [15:0] exp_out,
                        input int exp_lat, input logic exp_err);
    int lat;
    int nbusy;
    @(posedge clk); #1;
    drive(x, n, md);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    nbusy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"},  lat, exp_lat);
    chk({nm, "_busy"}, nbusy, exp_lat - 1);
    chk({nm, "_out"},  {16'd0, bus.shift_out}, {16'd0, exp_out});
    chk({nm, "_err"},  {31'd0, bus.err}, {31'd0, exp_err});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int ndone;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.shift_in  = 16'h0000;
    bus.shift_val = 4'd0;
    bus.mode      = 2'b00;

    #7;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err",  {31'd0, bus.err},  32'd0);
    chk("rst_out",  {16'd0, bus.shift_out}, 32'h0000);
    chk("rst_flag", {29'd0, bus.flag}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("srl8000x15", 16'h8000, 4'd15, 2'b00, 16'h0001, 15, 1'b0);
    chk("srl8000x15_flag", {29'd0, bus.flag}, 32'd0);
    run_op("rol8001x1",  16'h8001, 4'd1,  2'b01, 16'h0003, 1, 1'b0);
    run_op("rol1234x4",  16'h1234, 4'd4,  2'b01, 16'h2341, 4, 1'b0);
    run_op("rol8001x15", 16'h8001, 4'd15, 2'b01, 16'hC000, 15, 1'b0);
    run_op("srlFFFFx0",  16'hFFFF, 4'd0,  2'b00, 16'hFFFF, 1, 1'b0);
    run_op("srl0001x1",  16'h0001, 4'd1,  2'b00, 16'h0000, 1, 1'b0);
    chk("srl0001x1_flag", {29'd0, bus.flag}, 32'd1);
    run_op("illegal",    16'hBEEF, 4'd5,  2'b11, 16'h0000, 1, 1'b1);
    chk("illegal_flag", {29'd0, bus.flag}, 32'd1);
    run_op("srl00FFx3",  16'h00FF, 4'd3,  2'b00, 16'h001F, 3, 1'b0);
    run_op("mode10",     16'h8000, 4'd3,  2'b10, 16'h1000, 3, 1'b0);

    // Start pulse while running is dropped.
    @(posedge clk); #1;
    drive(16'hF0F0, 4'd8, 2'b00);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    repeat (2) begin @(posedge clk); #1; cyc++; end
    drive(16'h1111, 4'd2, 2'b01);
    @(posedge clk); #1; cyc++;
    bus.start = 1'b0;
    while (!bus.done && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("ignore_lat", cyc, 8);
    chk("ignore_out", {16'd0, bus.shift_out}, 32'h00F0);

    // Holding start in DONE: accepted, done not repeated next cycle.
    drive(16'h0001, 4'd2, 2'b01);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_no_repeat", {31'd0, bus.done}, 32'd0);
    chk("b2b_busy",      {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_out",  {16'd0, bus.shift_out}, 32'h0004);

    // One-edge request from DONE: done repeats.
    drive(16'hABCD, 4'd0, 2'b00);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b0_done", {31'd0, bus.done}, 32'd1);
    chk("b2b0_out",  {16'd0, bus.shift_out}, 32'hABCD);

    // Asynchronous reset in the middle of an SRL by 10.
    @(posedge clk); #1;
    drive(16'hABCD, 4'd10, 2'b00);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_out",  {16'd0, bus.shift_out}, 32'h0000);
    chk("abort_flag", {29'd0, bus.flag}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op("post_rst", 16'h1234, 4'd4, 2'b01, 16'h2341, 4, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_seq_shift_unit
